ct_rtu_preg_alloc_ctrl: RTL

Physical-register allocation controller for the 96-entry physical register file. It holds a 96-bit free vector and keeps two pre-picked candidate registers, encoded from one-hot to 7-bit preg numbers, ready for rename. Retired pregs are returned through two release ports. A flush reloads the whole free vector. The block sits in the RTU next to the PST and feeds preg numbers to IDU rename.

---
 rtl/ct_rtu_preg_alloc_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ct_rtu_preg_alloc_ctrl.sv
// Physical-register allocation controller: 96-entry free vector plus two
// pre-picked rename slots (lowest and highest free preg), release ports and flush reload.
module ct_rtu_preg_alloc_ctrl #(
    parameter int ARCH_NUM = 32
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic [1:0]  alloc_take,
    output logic [1:0]  alloc_vld,
    output logic [6:0]  alloc_preg0,
    output logic [6:0]  alloc_preg1,
    input  logic [1:0]  rel_vld,
    input  logic [6:0]  rel_preg0,
    input  logic [6:0]  rel_preg1,
    input  logic        flush_vld,
    input  logic [95:0] flush_free_mask,
    output logic [6:0]  free_cnt
);

    localparam int          PREG_NUM   = 96;
    localparam logic [95:0] RESET_FREE = ~((96'd1 << ARCH_NUM) - 96'd1);
    localparam logic [6:0]  RESET_CNT  = 7'(PREG_NUM - ARCH_NUM);

    logic [95:0] freeVec_q, freeVec_d;
    logic        slot0Vld_q, slot0Vld_d;
    logic        slot1Vld_q, slot1Vld_d;
    logic [6:0]  slot0Preg_q, slot0Preg_d;
    logic [6:0]  slot1Preg_q, slot1Preg_d;
    logic [6:0]  freeCnt_q, freeCnt_d;

    logic        refill0, refill1;
    logic [95:0] pick0Oh, pick1Src, pick1Oh;
    logic [95:0] load0Oh, load1Oh;
    logic [95:0] relOh0, relOh1;

    function automatic logic [95:0] lowestOh(input logic [95:0] v);
        return v & (~v + 96'd1);
    endfunction

    function automatic logic [95:0] highestOh(input logic [95:0] v);
        logic [95:0] oh;
        logic        found;
        oh    = '0;
        found = 1'b0;
        for (int i = PREG_NUM - 1; i >= 0; i--) begin
            if (v[i] && !found) begin
                oh[i] = 1'b1;
                found = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [6:0] onehotEnc(input logic [95:0] oh);
        logic [6:0] enc;
        enc = '0;
        for (int i = 0; i < PREG_NUM; i++) begin
            if (oh[i]) enc = enc | 7'(i);
        end
        return enc;
    endfunction

    function automatic logic [6:0] popCount(input logic [95:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < PREG_NUM; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

    // Out-of-range preg numbers decode to nothing, so they never touch the vector.
    function automatic logic [95:0] releaseOh(input logic vld, input logic [6:0] preg);
        logic [95:0] oh;
        oh = '0;
        if (vld && (preg < 7'(PREG_NUM))) oh = 96'd1 << preg;
        return oh;
    endfunction

    always_comb begin
        refill0  = !slot0Vld_q || alloc_take[0];
        refill1  = !slot1Vld_q || alloc_take[1];
        pick0Oh  = lowestOh(freeVec_q);
        pick1Src = refill0 ? (freeVec_q & ~pick0Oh) : freeVec_q;
        pick1Oh  = highestOh(pick1Src);
        load0Oh  = refill0 ? pick0Oh : '0;
        load1Oh  = refill1 ? pick1Oh : '0;
        relOh0   = releaseOh(rel_vld[0], rel_preg0);
        relOh1   = releaseOh(rel_vld[1], rel_preg1);
    end

    // Flush overrides refills and releases; otherwise picks leave and releases join.
    always_comb begin
        freeVec_d   = (freeVec_q & ~(load0Oh | load1Oh)) | relOh0 | relOh1;
        slot0Vld_d  = slot0Vld_q;
        slot0Preg_d = slot0Preg_q;
        slot1Vld_d  = slot1Vld_q;
        slot1Preg_d = slot1Preg_q;
        if (flush_vld) begin
            freeVec_d   = flush_free_mask;
            slot0Vld_d  = 1'b0;
            slot0Preg_d = '0;
            slot1Vld_d  = 1'b0;
            slot1Preg_d = '0;
        end else begin
            if (refill0) begin
                slot0Vld_d  = |pick0Oh;
                slot0Preg_d = onehotEnc(pick0Oh);
            end
            if (refill1) begin
                slot1Vld_d  = |pick1Oh;
                slot1Preg_d = onehotEnc(pick1Oh);
            end
        end
        freeCnt_d = popCount(freeVec_d);
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            freeVec_q   <= RESET_FREE;
            slot0Vld_q  <= 1'b0;
            slot0Preg_q <= '0;
            slot1Vld_q  <= 1'b0;
            slot1Preg_q <= '0;
            freeCnt_q   <= RESET_CNT;
        end else begin
            freeVec_q   <= freeVec_d;
            slot0Vld_q  <= slot0Vld_d;
            slot0Preg_q <= slot0Preg_d;
            slot1Vld_q  <= slot1Vld_d;
            slot1Preg_q <= slot1Preg_d;
            freeCnt_q   <= freeCnt_d;
        end
    end

    assign alloc_vld   = {slot1Vld_q, slot0Vld_q};
    assign alloc_preg0 = slot0Preg_q;
    assign alloc_preg1 = slot1Preg_q;
    assign free_cnt    = freeCnt_q;

    // Double-frees and duplicate releases would break the one-owner invariant.
    property pRelNotFree;
        @(posedge forever_cpuclk) disable iff (!cpurst_b)
            ((relOh0 | relOh1) & freeVec_q) == 96'd0;
    endproperty
    aRelNotFree: assert property (pRelNotFree);

    property pRelNotInSlot;
        @(posedge forever_cpuclk) disable iff (!cpurst_b)
            !((rel_vld[0] && slot0Vld_q && rel_preg0 == slot0Preg_q) ||
              (rel_vld[0] && slot1Vld_q && rel_preg0 == slot1Preg_q) ||
              (rel_vld[1] && slot0Vld_q && rel_preg1 == slot0Preg_q) ||
              (rel_vld[1] && slot1Vld_q && rel_preg1 == slot1Preg_q));
    endproperty
    aRelNotInSlot: assert property (pRelNotInSlot);

    property pRelDistinct;
        @(posedge forever_cpuclk) disable iff (!cpurst_b)
            (relOh0 & relOh1) == 96'd0;
    endproperty
    aRelDistinct: assert property (pRelDistinct);

endmodule
